// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit bus CPU control path: opcodes, control-word
// bit positions and the sequencer state encoding.
package cpu_pkg;

  localparam int CTRL_W = 15;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CTRL_PC_INC     = 0;
  localparam int CTRL_PC_OUT     = 1;
  localparam int CTRL_JUMP       = 2;
  localparam int CTRL_MAR_LOAD   = 3;
  localparam int CTRL_RAM_IN     = 4;
  localparam int CTRL_RAM_OUT    = 5;
  localparam int CTRL_IR_LOAD    = 6;
  localparam int CTRL_IR_OUT     = 7;
  localparam int CTRL_A_LOAD     = 8;
  localparam int CTRL_A_OUT      = 9;
  localparam int CTRL_ALU_OUT    = 10;
  localparam int CTRL_ALU_SUB    = 11;
  localparam int CTRL_B_LOAD     = 12;
  localparam int CTRL_OUT_LOAD   = 13;
  localparam int CTRL_FLAGS_LOAD = 14;

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  function automatic logic [CTRL_W-1:0] cbit(input int idx);
    logic [CTRL_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/microcode_decode.sv
// Combinational microcode ROM: maps (step, opcode, latched flags) to the
// control word and marks the final micro-step of each instruction.
module microcode_decode
  import cpu_pkg::*;
(
  input  state_t            state,
  input  logic [3:0]        opcode,
  input  logic              c_flag,
  input  logic              z_flag,
  output logic [CTRL_W-1:0] ctrl,
  output logic              last_step
);

  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    case (state)
      ST_T0: ctrl = cbit(CTRL_PC_OUT) | cbit(CTRL_MAR_LOAD);
      ST_T1: ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_IR_LOAD) | cbit(CTRL_PC_INC);
      ST_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA:
            ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_MAR_LOAD);
          OP_LDI: begin
            ctrl      = cbit(CTRL_IR_OUT) | cbit(CTRL_A_LOAD);
            last_step = 1'b1;
          end
          OP_JMP: begin
            ctrl      = cbit(CTRL_IR_OUT) | cbit(CTRL_JUMP);
            last_step = 1'b1;
          end
          OP_JC: begin
            if (c_flag) ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_JUMP);
            last_step = 1'b1;
          end
          OP_JZ: begin
            if (z_flag) ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_JUMP);
            last_step = 1'b1;
          end
          OP_OUT: begin
            ctrl      = cbit(CTRL_A_OUT) | cbit(CTRL_OUT_LOAD);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_T3: begin
        case (opcode)
          OP_LDA: begin
            ctrl      = cbit(CTRL_RAM_OUT) | cbit(CTRL_A_LOAD);
            last_step = 1'b1;
          end
          OP_ADD: ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_B_LOAD);
          OP_SUB: ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_B_LOAD) | cbit(CTRL_ALU_SUB);
          OP_STA: begin
            ctrl      = cbit(CTRL_A_OUT) | cbit(CTRL_RAM_IN);
            last_step = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      ST_T4: begin
        last_step = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB)
          ctrl = cbit(CTRL_ALU_OUT) | cbit(CTRL_A_LOAD) | cbit(CTRL_FLAGS_LOAD);
        if (opcode == OP_SUB)
          ctrl = ctrl | cbit(CTRL_ALU_SUB);
      end
      default: begin
        ctrl      = '0;
        last_step = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step sequencer for the bus CPU: owns the step/HALT state and the
// latched ALU flags, and gates the decoded control word onto the bus.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [3:0]        opcode,
  input  logic              CF,
  input  logic              ZF,
  output logic [CTRL_W-1:0] ctrl,
  output logic              c_flag,
  output logic              z_flag,
  output logic [2:0]        t_state,
  output logic              halted
);

  state_t            state;
  state_t            state_next;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              last_step;

  microcode_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .ctrl      (dec_ctrl),
    .last_step (last_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_T0;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ena && state != ST_HALT) begin
      if (last_step)
        state_next = (state == ST_T2 && opcode == OP_HLT) ? ST_HALT : ST_T0;
      else
        state_next = state_t'(state + 3'd1);
    end
  end

  // Flags only move on the ALU write-back step, so jumps see the last ADD/SUB result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (ena && dec_ctrl[CTRL_FLAGS_LOAD]) begin
      c_flag <= CF;
      z_flag <= ZF;
    end
  end

  always_comb begin
    ctrl    = '0;
    halted  = (state == ST_HALT);
    t_state = halted ? 3'd0 : state;
    if (rst_n && ena) ctrl = dec_ctrl;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the 8-bit bus CPU. It steps through fetch and execute micro-steps (T0–T4) and decodes the 4-bit opcode from the instruction register. Each cycle it drives the control word that gates every bus driver and register load, including `load`/`enable_output` of `accumulator_register`, `sub`/`enable_output` of `alu`, and the PC, MAR, RAM, IR, B and output-register strobes. It also latches the ALU carry and zero flags for conditional jumps.

## Interface
Parameters:
- none; opcodes and control-bit indices are constants in the shared package.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  step enable; 0 freezes state and zeroes `ctrl`
- `opcode`  in  4  upper nibble of instruction register
- `CF`  in  1  ALU carry out (combinational)
- `ZF`  in  1  ALU zero (combinational)
- `ctrl`  out  15  control word, bit map below
- `c_flag`  out  1  latched carry
- `z_flag`  out  1  latched zero
- `t_state`  out  3  current micro-step 0–4; debug
- `halted`  out  1  1 after HLT executes

## Operation
- `ctrl` bits:
  - 0 pc_inc, 1 pc_out, 2 jump, 3 mar_load, 4 ram_in
  - 5 ram_out, 6 ir_load, 7 ir_out, 8 a_load (accumulator `load`), 9 a_out (accumulator `enable_output`)
  - 10 alu_out (ALU `enable_output`), 11 alu_sub, 12 b_load, 13 out_load, 14 flags_load
- States: T0, T1, T2, T3, T4, HALT. `ctrl` is a Moore decode of (state, opcode, c_flag, z_flag).
- Fetch (all opcodes): T0 pc_out+mar_load; T1 ram_out+ir_load+pc_inc.
- Execute. The step marked "last" returns the sequencer to T0 on the next edge.
  - 0x0 NOP: T2 none (last).
  - 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load (last).
  - 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load (last).
  - 0x3 SUB: same as ADD, with alu_sub also asserted in T3 and T4.
  - 0x4 STA: T2 ir_out+mar_load; T3 a_out+ram_in (last).
  - 0x5 LDI: T2 ir_out+a_load (last).
  - 0x6 JMP: T2 ir_out+jump (last).
  - 0x7 JC: T2 ir_out+jump only if c_flag=1, otherwise none (last).
  - 0x8 JZ: as JC, using z_flag.
  - 0xE OUT: T2 a_out+out_load (last).
  - 0xF HLT: T2 none, next state HALT.
  - 0x9–0xD: decode as NOP.
- Flags: on an edge where flags_load=1 and ena=1, c_flag←CF and z_flag←ZF. Otherwise the flags hold.
- HALT: `ctrl`=0, `halted`=1, state held. Only reset exits HALT.
- `ena`=0: state and flags hold; `ctrl` forced to 0. Resuming continues at the held step.
- At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out) is asserted in any cycle. This invariant holds for every opcode and state.

## Timing
- Reset (async assert):
  - state=T0, c_flag=z_flag=0, halted=0, t_state=0.
  - `ctrl` forced to 0 while rst_n=0.
  - First control word after release is T0 fetch.
- Latency:
  - Each micro-step is one cycle.
  - Instruction lengths: NOP/LDI/JMP/JC/JZ/OUT 3 cycles; LDA/STA 4; ADD/SUB 5; HLT 3 cycles, then HALT.
- Consumers latch on the rising edge that ends the cycle in which their strobe is high. `opcode` must be stable from T2 onward.
- Reset mid-instruction aborts it immediately; flags clear.
- opcode changes during T0/T1 are ignored; only the value at T2+ is decoded.
- t_state never exceeds 4. Wrap to T0 occurs only at a "last" step.

## Structure
- Shared package `cpu_pkg`: opcode localparams (OP_NOP…OP_HLT), `ctrl` bit-index constants (CTRL_PC_INC…CTRL_FLAGS_LOAD), CTRL_W=15, state encoding.
- One sub-module, `microcode_decode`: purely combinational (state, opcode, c_flag, z_flag) → ctrl, last_step.
- Step counter, HALT state and flag registers live in `control_sequencer`.

## Test plan
- Reset then 2 cycles with ena=1, opcode=0x1 → ctrl=0x000A (T0), then 0x0061 (T1); during rst_n=0, ctrl=0.
- opcode=0x2, CF=1, ZF=0 → T2 0x0088, T3 0x1020, T4 0x4500; c_flag=1, z_flag=0 after T4; next cycle t_state=0.
- opcode=0x3 → alu_sub (bit 11) high in T3 and T4 only; 5-cycle instruction.
- JZ with z_flag=0 → T2 ctrl=0; with z_flag=1 → T2 ctrl=0x0084; both return to T0.
- opcode=0xF → T2 ctrl=0, then halted=1 and ctrl=0 for 20 cycles; rst_n pulse → halted=0, T0.
- ena=0 during T3 of ADD for 5 cycles → ctrl=0, t_state=3 held; ena=1 → T3 word 0x1020 reissued. All-opcode sweep confirms ≤1 bus driver per cycle.
